// File: rtl/wts_pkg.sv
// Shared types and constants for the wavetable envelope multiplier.
package wts_pkg;

    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned ENV_W       = 8;
    localparam int unsigned VOL_W       = 4;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned STEP_W      = 2;
    localparam int unsigned WTS_ENV_MAX = 128;
    localparam int unsigned ENV_SHIFT   = 7;
    localparam int unsigned VOL_SHIFT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENV  = 2'd1,
        ST_VOL  = 2'd2
    } wts_state_t;

endpackage

// File: rtl/wts_envelope_multiplier.sv
// Scales a wave sample by the ADSR envelope (radix-4 shift-add, 5 clk fixed latency).
// Optional channel volume scaling is enabled by defining WTS_VOLUME_EN.
module wts_envelope_multiplier
    import wts_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       active,
    input  logic [ENV_W-1:0]           envelope,
    input  logic signed [SAMPLE_W-1:0] sample,
`ifdef WTS_VOLUME_EN
    input  logic [VOL_W-1:0]           reg_volume,
`endif
    output logic signed [SAMPLE_W-1:0] channel_out,
    output logic                       out_valid
);

    wts_state_t                 state_q, state_d;
    logic [STEP_W-1:0]          step_q, step_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic [ENV_W-1:0]           env_q, env_d;
    logic signed [SAMPLE_W-1:0] out_d;
    logic                       valid_d;

    logic [1:0]                 env_pair;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [ACC_W-1:0]    partial;
    logic signed [SAMPLE_W-1:0] y1;
    logic signed [SAMPLE_W-1:0] y2;

`ifdef WTS_VOLUME_EN
    logic [VOL_W-1:0]           vol_q, vol_d;
    logic signed [ACC_W-1:0]    y1_ext;
    logic signed [ACC_W-1:0]    vol_ext;
`endif

    // Datapath: one radix-4 partial product per ENV step, then the output scaling.
    always_comb begin
        env_pair   = env_q[{step_q, 1'b0} +: 2];
        sample_ext = ACC_W'(sample_q);
        case (env_pair)
            2'd0:    partial = '0;
            2'd1:    partial = sample_ext;
            2'd2:    partial = sample_ext <<< 1;
            default: partial = sample_ext + (sample_ext <<< 1);
        endcase
        y1 = SAMPLE_W'(acc_q >>> ENV_SHIFT);
`ifdef WTS_VOLUME_EN
        y1_ext  = ACC_W'(y1);
        vol_ext = ACC_W'({1'b0, vol_q}) + ACC_W'(1);
        y2      = SAMPLE_W'((y1_ext * vol_ext) >>> VOL_SHIFT);
`else
        y2      = y1;
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        env_d    = env_q;
        out_d    = channel_out;
        valid_d  = 1'b0;
`ifdef WTS_VOLUME_EN
        vol_d    = vol_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    sample_d = sample;
                    env_d    = (envelope > ENV_W'(WTS_ENV_MAX)) ? ENV_W'(WTS_ENV_MAX) : envelope;
`ifdef WTS_VOLUME_EN
                    vol_d    = reg_volume;
`endif
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = ST_ENV;
                end
            end
            ST_ENV: begin
                acc_d  = acc_q + (partial <<< {step_q, 1'b0});
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(3)) begin
                    step_d  = '0;
                    state_d = ST_VOL;
                end
            end
            ST_VOL: begin
                out_d   = y2;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            env_q       <= '0;
            channel_out <= '0;
            out_valid   <= 1'b0;
`ifdef WTS_VOLUME_EN
            vol_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            env_q       <= env_d;
            channel_out <= out_d;
            out_valid   <= valid_d;
`ifdef WTS_VOLUME_EN
            vol_q       <= vol_d;
`endif
        end
    end

endmodule

// File: tb/tb_wts_envelope_multiplier.sv
// Scoreboard bench for wts_envelope_multiplier; honours WTS_VOLUME_EN when defined.
module tb_wts_envelope_multiplier;

    logic              clk;
    logic              reset;
    logic              active;
    logic [7:0]        envelope;
    logic signed [7:0] sample;
    logic [3:0]        reg_volume;
    logic signed [7:0] channel_out;
    logic              out_valid;

    typedef struct {
        logic signed [7:0] val;
        int                due;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    logic signed [7:0] last_out = 0;

    wts_envelope_multiplier dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .envelope    (envelope),
        .sample      (sample),
`ifdef WTS_VOLUME_EN
        .reg_volume  (reg_volume),
`endif
        .channel_out (channel_out),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #23 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on every out_valid, otherwise checks that channel_out holds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL extra_valid: out_valid with no pending result, channel_out=%0d cyc=%0d", channel_out, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (channel_out !== e.val || cyc != e.due) begin
                            errors++;
                            $display("FAIL result: got %0d at cyc %0d, expected %0d at cyc %0d", channel_out, cyc, e.val, e.due);
                        end
                        last_out = e.val;
                    end
                end else begin
                    checks++;
                    if (channel_out !== last_out) begin
                        errors++;
                        $display("FAIL hold: channel_out=%0d expected %0d cyc=%0d", channel_out, last_out, cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic signed [7:0] s, input logic [7:0] e, input logic [3:0] v,
                         input logic signed [7:0] exp_novol, input logic signed [7:0] exp_vol);
        exp_t x;
        @(negedge clk);
        sample     = s;
        envelope   = e;
        reg_volume = v;
        active     = 1'b1;
`ifdef WTS_VOLUME_EN
        x.val = exp_vol;
`else
        x.val = exp_novol;
`endif
        x.due = cyc + 6;
        sb.push_back(x);
        @(negedge clk);
        active     = 1'b0;
        sample     = 8'($urandom);
        envelope   = 8'($urandom);
        reg_volume = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        reset      = 1'b1;
        active     = 1'b0;
        sample     = '0;
        envelope   = '0;
        reg_volume = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", channel_out, 8'd0);
        chk("reset_valid", {7'd0, out_valid}, 8'd0);
        reset = 1'b0;
        idle(2);

        // sample, envelope, volume, expected without / with volume
        issue(  127, 8'd128, 4'd15,  127,  127); idle(6);
        issue( -128, 8'd64,  4'd15,  -64,  -64); idle(6);
        issue(   -1, 8'd1,   4'd15,   -1,   -1); idle(6);
        issue(   50, 8'd0,   4'd15,    0,    0); idle(6);
        issue(  100, 8'd200, 4'd15,  100,  100); idle(6);
        issue(  100, 8'd128, 4'd7,   100,   50); idle(6);
        issue(   77, 8'd37,  4'd3,    22,    5); idle(6);
        issue(  -90, 8'd100, 4'd0,   -71,   -5); idle(6);
        issue( -128, 8'd128, 4'd15, -128, -128); idle(6);
        issue(    1, 8'd127, 4'd9,     0,    0); idle(6);
        issue(  -37, 8'd255, 4'd11,  -37,  -28); idle(6);
        issue(   64, 8'd3,   4'd15,    1,    1); idle(4);

        // Back-to-back issue: next active lands on the edge right after the VOL edge.
        issue(   10, 8'd128, 4'd15,   10,   10); idle(4);
        issue(  -20, 8'd128, 4'd15,  -20,  -20); idle(6);

        // Second active two clk after the first must be ignored.
        @(negedge clk);
        sample = 8'sd60; envelope = 8'd128; reg_volume = 4'd15; active = 1'b1;
        begin
            exp_t x;
            x.val = 60;
            x.due = cyc + 6;
            sb.push_back(x);
        end
        @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        sample = -8'sd5; envelope = 8'd64; reg_volume = 4'd0; active = 1'b1;
        @(negedge clk);
        active = 1'b0;
        idle(8);

        // Reset in the middle of ENV: outputs clear at once, no partial result.
        issue(  33, 8'd128, 4'd15, 33, 33);
        idle(1);
        reset = 1'b1;
        #1;
        chk("midreset_out", channel_out, 8'd0);
        chk("midreset_valid", {7'd0, out_valid}, 8'd0);
        void'(sb.pop_back());
        last_out = 0;
        idle(2);
        reset = 1'b0;
        idle(8);
        issue(  -77, 8'd128, 4'd7, -77, -39); idle(2);

        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never appeared", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
